// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART receive path.
package uart_pkg;

  typedef logic [7:0] byte_t;

  localparam int unsigned UART_RX_DEFAULT_DEPTH = 8;
  localparam int unsigned UART_ERRCNT_WIDTH     = 8;

endpackage

// File: rtl/uart_byte_fifo.sv
// Small synchronous byte FIFO with separate occupancy count; a push into a full queue is
// accepted only when a pop frees a slot in the same cycle.
module uart_byte_fifo
  import uart_pkg::*;
#(
  parameter int unsigned Depth = UART_RX_DEFAULT_DEPTH,
  localparam int unsigned PtrWidth = $clog2(Depth),
  localparam int unsigned CntWidth = PtrWidth + 1
) (
  input  logic                clk,
  input  logic                nReset,
  input  logic                push_i,
  input  byte_t               wrData_i,
  input  logic                pop_i,
  output byte_t               rdData_o,
  output logic [CntWidth-1:0] count_o,
  output logic                empty_o,
  output logic                pushAccept_o
);

  byte_t               mem [Depth];
  logic [PtrWidth-1:0] wrPtrQ, wrPtrD;
  logic [PtrWidth-1:0] rdPtrQ, rdPtrD;
  logic [CntWidth-1:0] countQ, countD;
  logic                full;
  logic                popOk;
  logic                pushOk;

  assign full   = (countQ == CntWidth'(Depth));
  assign popOk  = pop_i && (countQ != '0);
  assign pushOk = push_i && (!full || popOk);

  always_comb begin
    wrPtrD = wrPtrQ;
    rdPtrD = rdPtrQ;
    countD = countQ;
    // Pointers wrap naturally because Depth is a power of two.
    if (pushOk) wrPtrD = wrPtrQ + PtrWidth'(1);
    if (popOk)  rdPtrD = rdPtrQ + PtrWidth'(1);
    unique case ({pushOk, popOk})
      2'b10:   countD = countQ + CntWidth'(1);
      2'b01:   countD = countQ - CntWidth'(1);
      default: countD = countQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nReset) begin
      wrPtrQ <= '0;
      rdPtrQ <= '0;
      countQ <= '0;
    end else begin
      wrPtrQ <= wrPtrD;
      rdPtrQ <= rdPtrD;
      countQ <= countD;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (pushOk) mem[wrPtrQ] <= wrData_i;
  end

  assign rdData_o     = mem[rdPtrQ];
  assign count_o      = countQ;
  assign empty_o      = (countQ == '0);
  assign pushAccept_o = pushOk;

endmodule

// File: rtl/uart_rx_buffer.sv
// Receive-side byte buffer: stages receiver output, queues bytes, and keeps sticky
// overrun and saturating framing-error status for polling.
module uart_rx_buffer
  import uart_pkg::*;
#(
  parameter int unsigned Depth         = UART_RX_DEFAULT_DEPTH,
  parameter int unsigned ErrCountWidth = UART_ERRCNT_WIDTH
) (
  input  logic                     clk,
  input  logic                     nReset,
  input  logic [7:0]               rxData,
  input  logic                     rxDone,
  input  logic                     rxErr,
  output logic [7:0]               outData,
  output logic                     outValid,
  input  logic                     outReady,
  output logic [$clog2(Depth):0]   count,
  output logic                     overrun,
  output logic [ErrCountWidth-1:0] errCount,
  input  logic                     clearFlags
);

  logic                     stagedQ;
  logic                     pushReq;
  logic                     pop;
  logic                     fifoEmpty;
  logic                     pushAccept;
  logic                     dropEvent;
  logic                     overrunQ, overrunD;
  logic [ErrCountWidth-1:0] errCountQ, errCountD;
  byte_t                    headData;

  // Receiver data is valid one cycle after rxDone; an rxErr in that cycle kills the byte.
  assign pushReq   = stagedQ && !rxErr;
  assign pop       = outValid && outReady;
  assign dropEvent = pushReq && !pushAccept;

  uart_byte_fifo #(
    .Depth(Depth)
  ) u_fifo (
    .clk         (clk),
    .nReset      (nReset),
    .push_i      (pushReq),
    .wrData_i    (rxData),
    .pop_i       (pop),
    .rdData_o    (headData),
    .count_o     (count),
    .empty_o     (fifoEmpty),
    .pushAccept_o(pushAccept)
  );

  // A new event in the same cycle as clearFlags takes priority over the clear.
  always_comb begin
    overrunD = overrunQ;
    if (dropEvent) begin
      overrunD = 1'b1;
    end else if (clearFlags) begin
      overrunD = 1'b0;
    end
  end

  always_comb begin
    errCountD = errCountQ;
    if (rxErr) begin
      if (clearFlags) begin
        errCountD = ErrCountWidth'(1);
      end else if (!(&errCountQ)) begin
        errCountD = errCountQ + ErrCountWidth'(1);
      end
    end else if (clearFlags) begin
      errCountD = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!nReset) begin
      stagedQ   <= 1'b0;
      overrunQ  <= 1'b0;
      errCountQ <= '0;
    end else begin
      stagedQ   <= rxDone;
      overrunQ  <= overrunD;
      errCountQ <= errCountD;
    end
  end

  // outValid depends only on registered occupancy, never on outReady.
  assign outValid = !fifoEmpty;
  assign outData  = headData;
  assign overrun  = overrunQ;
  assign errCount = errCountQ;

endmodule

// File: tb/tb_uart_rx_buffer.sv
// Bench for uart_rx_buffer: vector table, directed corner sequences and random traffic
// compared against a queue-based reference model.
module tb_uart_rx_buffer;

  localparam int unsigned Depth = 8;

  logic       clk = 1'b0;
  logic       nReset;
  logic [7:0] rxData;
  logic       rxDone;
  logic       rxErr;
  logic [7:0] outData;
  logic       outValid;
  logic       outReady;
  logic [3:0] count;
  logic       overrun;
  logic [7:0] errCount;
  logic       clearFlags;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [7:0] mq[$];
  bit         mOv;
  int         mEc;
  bit         mSt;
  logic [7:0] gotQ[$];

  typedef struct {
    string      name;
    logic       rxDone;
    logic       rxErr;
    logic [7:0] rxData;
    logic       outReady;
    logic       clearFlags;
    logic       expValid;
    int         expCount;
    logic [7:0] expData;
    logic       expOverrun;
    int         expErr;
  } vec_t;

  vec_t vecs[$];

  uart_rx_buffer #(
    .Depth        (Depth),
    .ErrCountWidth(8)
  ) dut (
    .clk       (clk),
    .nReset    (nReset),
    .rxData    (rxData),
    .rxDone    (rxDone),
    .rxErr     (rxErr),
    .outData   (outData),
    .outValid  (outValid),
    .outReady  (outReady),
    .count     (count),
    .overrun   (overrun),
    .errCount  (errCount),
    .clearFlags(clearFlags)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkModel();
    chk("m_valid", {31'd0, outValid}, {31'd0, mq.size() != 0});
    chk("m_count", {28'd0, count}, mq.size());
    chk("m_overrun", {31'd0, overrun}, {31'd0, mOv});
    chk("m_errcount", {24'd0, errCount}, mEc);
    if (mq.size() != 0) chk("m_data", {24'd0, outData}, {24'd0, mq[0]});
  endtask

  // Advance the model one clock from the currently driven inputs, then the DUT.
  task automatic tick();
    bit         popM;
    bit         acc;
    bit         drop;
    logic [7:0] tmp;
    if (outValid && outReady) gotQ.push_back(outData);
    if (!nReset) begin
      mq.delete();
      mOv = 0;
      mEc = 0;
      mSt = 0;
    end else begin
      popM = (mq.size() != 0) && outReady;
      acc  = 0;
      drop = 0;
      if (mSt && !rxErr) begin
        if (mq.size() < Depth || popM) acc = 1;
        else drop = 1;
      end
      if (popM) tmp = mq.pop_front();
      if (acc) mq.push_back(rxData);
      if (drop) mOv = 1;
      else if (clearFlags) mOv = 0;
      if (rxErr) mEc = clearFlags ? 1 : ((mEc < 255) ? mEc + 1 : 255);
      else if (clearFlags) mEc = 0;
      mSt = rxDone;
    end
    @(posedge clk);
    #1;
    checkModel();
  endtask

  task automatic sendByte(input logic [7:0] b);
    rxDone = 1'b1;
    tick();
    rxDone = 1'b0;
    rxData = b;
    tick();
  endtask

  task automatic clearAll();
    clearFlags = 1'b1;
    tick();
    clearFlags = 1'b0;
  endtask

  function automatic vec_t mk(input string n, input logic d, input logic e, input logic [7:0] x,
                              input logic r, input logic c, input logic ev, input int ecnt,
                              input logic [7:0] ed, input logic eo, input int ee);
    vec_t v;
    v.name = n; v.rxDone = d; v.rxErr = e; v.rxData = x; v.outReady = r; v.clearFlags = c;
    v.expValid = ev; v.expCount = ecnt; v.expData = ed; v.expOverrun = eo; v.expErr = ee;
    return v;
  endfunction

  initial begin
    nReset = 1'b0; rxData = 8'h00; rxDone = 1'b0; rxErr = 1'b0;
    outReady = 1'b0; clearFlags = 1'b0;
    tick();
    tick();
    chk("rst_valid", {31'd0, outValid}, 0);
    chk("rst_count", {28'd0, count}, 0);
    chk("rst_overrun", {31'd0, overrun}, 0);
    chk("rst_errcount", {24'd0, errCount}, 0);
    nReset = 1'b1;

    //             name          done err data   rdy clr  v cnt data  ov err
    vecs.push_back(mk("stage",     1, 0, 8'h00, 0, 0,   0, 0, 8'h00, 0, 0));
    vecs.push_back(mk("push_a5",   0, 0, 8'hA5, 0, 0,   1, 1, 8'hA5, 0, 0));
    vecs.push_back(mk("hold_a5",   0, 0, 8'h00, 0, 0,   1, 1, 8'hA5, 0, 0));
    vecs.push_back(mk("pop_a5",    0, 0, 8'h00, 1, 0,   0, 0, 8'h00, 0, 0));
    vecs.push_back(mk("stage2",    1, 0, 8'h00, 0, 0,   0, 0, 8'h00, 0, 0));
    vecs.push_back(mk("err_cancel",0, 1, 8'h77, 0, 0,   0, 0, 8'h00, 0, 1));
    vecs.push_back(mk("err_again", 0, 1, 8'h00, 0, 0,   0, 0, 8'h00, 0, 2));
    vecs.push_back(mk("clr_race",  0, 1, 8'h00, 0, 1,   0, 0, 8'h00, 0, 1));
    vecs.push_back(mk("clr_only",  0, 0, 8'h00, 0, 1,   0, 0, 8'h00, 0, 0));
    vecs.push_back(mk("b2b_stage", 1, 0, 8'h00, 0, 0,   0, 0, 8'h00, 0, 0));
    vecs.push_back(mk("b2b_3c",    1, 0, 8'h3C, 0, 0,   1, 1, 8'h3C, 0, 0));
    vecs.push_back(mk("b2b_c3",    0, 0, 8'hC3, 0, 0,   1, 2, 8'h3C, 0, 0));
    vecs.push_back(mk("b2b_pop1",  0, 0, 8'h00, 1, 0,   1, 1, 8'hC3, 0, 0));
    vecs.push_back(mk("b2b_pop2",  0, 0, 8'h00, 1, 0,   0, 0, 8'h00, 0, 0));

    foreach (vecs[i]) begin
      rxDone = vecs[i].rxDone; rxErr = vecs[i].rxErr; rxData = vecs[i].rxData;
      outReady = vecs[i].outReady; clearFlags = vecs[i].clearFlags;
      tick();
      chk({vecs[i].name, "_valid"}, {31'd0, outValid}, {31'd0, vecs[i].expValid});
      chk({vecs[i].name, "_count"}, {28'd0, count}, vecs[i].expCount);
      if (vecs[i].expValid) chk({vecs[i].name, "_data"}, {24'd0, outData}, {24'd0, vecs[i].expData});
      chk({vecs[i].name, "_overrun"}, {31'd0, overrun}, {31'd0, vecs[i].expOverrun});
      chk({vecs[i].name, "_err"}, {24'd0, errCount}, vecs[i].expErr);
    end
    rxDone = 0; rxErr = 0; outReady = 0; clearFlags = 0;

    // Fill past capacity: ninth byte dropped, overrun set, oldest kept.
    for (int i = 1; i <= 9; i++) sendByte(8'(i));
    chk("fill_count", {28'd0, count}, 8);
    chk("fill_overrun", {31'd0, overrun}, 1);
    for (int i = 1; i <= 8; i++) begin
      chk("fill_drain", {24'd0, outData}, i);
      outReady = 1'b1;
      tick();
      outReady = 1'b0;
    end
    chk("fill_empty", {28'd0, count}, 0);
    clearAll();
    chk("fill_clr_overrun", {31'd0, overrun}, 0);

    // Full with simultaneous pop: push accepted, no overrun.
    for (int i = 0; i < 8; i++) sendByte(8'h10 + 8'(i));
    rxDone = 1'b1;
    tick();
    rxDone = 1'b0; rxData = 8'h55; outReady = 1'b1;
    tick();
    outReady = 1'b0;
    chk("fullpop_count", {28'd0, count}, 8);
    chk("fullpop_overrun", {31'd0, overrun}, 0);
    for (int i = 1; i <= 8; i++) begin
      chk("fullpop_drain", {24'd0, outData}, (i == 8) ? 32'h55 : 32'h10 + i);
      outReady = 1'b1;
      tick();
      outReady = 1'b0;
    end

    // Error counter saturation.
    for (int i = 0; i < 300; i++) begin
      rxErr = 1'b1;
      tick();
      rxErr = 1'b0;
      tick();
    end
    chk("err_saturate", {24'd0, errCount}, 255);
    clearAll();
    chk("err_cleared", {24'd0, errCount}, 0);

    // Streaming across pointer wrap.
    gotQ.delete();
    outReady = 1'b1;
    for (int i = 0; i < 20; i++) sendByte(8'hA0 + 8'(i));
    tick();
    tick();
    outReady = 1'b0;
    chk("wrap_len", gotQ.size(), 20);
    for (int i = 0; i < 20 && i < gotQ.size(); i++) chk("wrap_order", {24'd0, gotQ[i]}, 32'hA0 + i);

    // Reset with bytes queued and one staged.
    for (int i = 0; i < 3; i++) sendByte(8'hE0 + 8'(i));
    chk("rstq_count_pre", {28'd0, count}, 3);
    rxDone = 1'b1;
    tick();
    rxDone = 1'b0; nReset = 1'b0; rxData = 8'h99;
    tick();
    chk("rstq_count", {28'd0, count}, 0);
    chk("rstq_valid", {31'd0, outValid}, 0);
    nReset = 1'b1;
    tick();
    chk("rstq_staged_gone", {28'd0, count}, 0);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      rxDone     = ($urandom % 2) == 0;
      rxErr      = ($urandom % 16) == 0;
      clearFlags = ($urandom % 32) == 0;
      outReady   = ($urandom % 10) < 4;
      rxData     = 8'($urandom);
      nReset     = ($urandom % 500) != 0;
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
